nmlo_pulse_seq: RTL and testbench

//  Neuron multi-level-output (NMLO) conversion sequencer. Started by nmlo_trigger from the matmul DAC-to-ADC loop.

---
 rtl/nmlo_pkg.sv | 34 +++
 rtl/nmlo_phase_timer.sv | 45 ++++
 rtl/nmlo_pulse_seq.sv | 196 +++++++++++++++++++
 tb/tb_nmlo_pulse_seq.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/nmlo_pkg.sv
// nmlo_pkg: shared definitions for the NMLO conversion sequencer.
//  - state encodings (4-bit) for the sequencer FSM
//  - default widths for comparator columns, counts and phase durations
//  - sat_inc: saturating increment used by the per-column counters
package nmlo_pkg;

  localparam int NMLO_NCOL   = 16;
  localparam int NMLO_CNT_W  = 8;
  localparam int NMLO_TIME_W = 8;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CLEAR = 4'd1,
    ST_SHARE = 4'd2,
    ST_INTEG = 4'd3,
    ST_LATCH = 4'd4,
    ST_DONE  = 4'd5
  } nmlo_state_e;

  // Adds inc to val but never goes beyond max_val. Callers widen their
  // count to 32 bits and truncate the result back to their own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                          input logic [31:0] max_val,
                                          input logic        inc);
    logic [31:0] res;
    if (inc && (val < max_val)) begin
      res = val + 32'd1;
    end else begin
      res = val;
    end
    return res;
  endfunction

endpackage

// File: rtl/nmlo_phase_timer.sv
// nmlo_phase_timer: loadable down-counter timing one share/integrate/latch
// phase. A length of 0 is treated as 1, so every phase lasts at least one
// cycle.
// Ports:
//  clk, rst : clock, asynchronous active-high reset
//  load     : load a new phase length (takes effect on the next edge)
//  len      : phase length in cycles
//  last     : 1 while the current cycle is the final cycle of the phase
module nmlo_phase_timer
  import nmlo_pkg::*;
#(
  parameter int TIME_W = NMLO_TIME_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TIME_W-1:0] len,
  output logic              last
);

  localparam logic [TIME_W-1:0] T_ZERO = {TIME_W{1'b0}};
  localparam logic [TIME_W-1:0] T_ONE  = {{(TIME_W-1){1'b0}}, 1'b1};

  logic [TIME_W-1:0] cnt_r;

  // Remaining-cycles counter: load len-1 (0 for len 0), then count to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= T_ZERO;
    end else if (load) begin
      if (len == T_ZERO) begin
        cnt_r <= T_ZERO;
      end else begin
        cnt_r <= len - T_ONE;
      end
    end else if (cnt_r != T_ZERO) begin
      cnt_r <= cnt_r - T_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign last = (cnt_r == T_ZERO);

endmodule

// File: rtl/nmlo_pulse_seq.sv
// nmlo_pulse_seq: neuron multi-level-output conversion sequencer.
// On trigger (sampled in IDLE) it captures the configuration, clears the
// column counts, then runs num_pulses rounds of share -> integrate -> latch.
// At the end of each latch phase every column count is incremented
// (saturating) by its comparator decision. idle/trigger form the same level
// handshake as the upstream matmul sequencer.
// Ports:
//  clk, rst    : clock, asynchronous active-high reset
//  trigger     : start request (level), only honoured in IDLE
//  num_pulses  : pulses per conversion, 0 = none
//  t_share/t_integ/t_latch : phase lengths in cycles (0 treated as 1)
//  comp_out    : comparator decisions, sampled on the last latch cycle
//  idle        : 1 = ready/done
//  share/integ/latch : neuron pulse outputs (mutually exclusive)
//  count_out   : column i at [i*CNT_W +: CNT_W], held from DONE to next CLEAR
//  count_valid : one-cycle pulse when count_out is final
// All control outputs are registered decodes of the state and lag it by one
// cycle.
module nmlo_pulse_seq
  import nmlo_pkg::*;
#(
  parameter int NCOL   = NMLO_NCOL,
  parameter int CNT_W  = NMLO_CNT_W,
  parameter int TIME_W = NMLO_TIME_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trigger,
  input  logic [7:0]            num_pulses,
  input  logic [TIME_W-1:0]     t_share,
  input  logic [TIME_W-1:0]     t_integ,
  input  logic [TIME_W-1:0]     t_latch,
  input  logic [NCOL-1:0]       comp_out,
  output logic                  idle,
  output logic                  share,
  output logic                  integ,
  output logic                  latch,
  output logic [NCOL*CNT_W-1:0] count_out,
  output logic                  count_valid
);

  localparam logic [31:0] SAT_MAX = (32'd1 << CNT_W) - 32'd1;

  nmlo_state_e       state_r;
  logic [7:0]        num_pulses_r;
  logic [TIME_W-1:0] t_share_r;
  logic [TIME_W-1:0] t_integ_r;
  logic [TIME_W-1:0] t_latch_r;
  logic [7:0]        pulse_idx_r;

  logic              tmr_load_s;
  logic [TIME_W-1:0] tmr_len_s;
  logic              tmr_last_s;
  logic              clear_s;
  logic              upd_s;

  nmlo_phase_timer #(.TIME_W(TIME_W)) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load_s),
    .len  (tmr_len_s),
    .last (tmr_last_s)
  );

  // Timer control: arm the length of the phase being entered next.
  always_comb begin
    tmr_load_s = 1'b0;
    tmr_len_s  = t_share_r;
    case (state_r)
      ST_CLEAR: begin
        tmr_load_s = 1'b1;
        tmr_len_s  = t_share_r;
      end
      ST_SHARE: begin
        tmr_load_s = tmr_last_s;
        tmr_len_s  = t_integ_r;
      end
      ST_INTEG: begin
        tmr_load_s = tmr_last_s;
        tmr_len_s  = t_latch_r;
      end
      ST_LATCH: begin
        // Loading on the final pulse is harmless: DONE ignores the timer.
        tmr_load_s = tmr_last_s;
        tmr_len_s  = t_share_r;
      end
      default: begin
        tmr_load_s = 1'b0;
        tmr_len_s  = t_share_r;
      end
    endcase
  end

  assign clear_s = (state_r == ST_CLEAR);
  assign upd_s   = (state_r == ST_LATCH) && tmr_last_s;

  // Sequencer FSM with registered, state-decoded outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      num_pulses_r <= 8'd0;
      t_share_r    <= {TIME_W{1'b0}};
      t_integ_r    <= {TIME_W{1'b0}};
      t_latch_r    <= {TIME_W{1'b0}};
      pulse_idx_r  <= 8'd0;
      idle         <= 1'b0;
      share        <= 1'b0;
      integ        <= 1'b0;
      latch        <= 1'b0;
      count_valid  <= 1'b0;
    end else begin
      idle        <= (state_r == ST_IDLE);
      share       <= (state_r == ST_SHARE);
      integ       <= (state_r == ST_INTEG);
      latch       <= (state_r == ST_LATCH);
      count_valid <= (state_r == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          if (trigger) begin
            num_pulses_r <= num_pulses;
            t_share_r    <= t_share;
            t_integ_r    <= t_integ;
            t_latch_r    <= t_latch;
            state_r      <= ST_CLEAR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_CLEAR: begin
          pulse_idx_r <= 8'd0;
          if (num_pulses_r == 8'd0) begin
            state_r <= ST_DONE;
          end else begin
            state_r <= ST_SHARE;
          end
        end
        ST_SHARE: begin
          if (tmr_last_s) begin
            state_r <= ST_INTEG;
          end else begin
            state_r <= ST_SHARE;
          end
        end
        ST_INTEG: begin
          if (tmr_last_s) begin
            state_r <= ST_LATCH;
          end else begin
            state_r <= ST_INTEG;
          end
        end
        ST_LATCH: begin
          if (tmr_last_s) begin
            pulse_idx_r <= pulse_idx_r + 8'd1;
            // pulse_idx stays below num_pulses, so +1 cannot wrap here.
            if ((pulse_idx_r + 8'd1) == num_pulses_r) begin
              state_r <= ST_DONE;
            end else begin
              state_r <= ST_SHARE;
            end
          end else begin
            state_r <= ST_LATCH;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < NCOL; gi++) begin : g_col
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] next_s;

    assign next_s = CNT_W'(sat_inc(32'(count_r), SAT_MAX, comp_out[gi]));

    // Column count: cleared in CLEAR, bumped on the last latch cycle.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        count_r <= {CNT_W{1'b0}};
      end else if (clear_s) begin
        count_r <= {CNT_W{1'b0}};
      end else if (upd_s) begin
        count_r <= next_s;
      end else begin
        count_r <= count_r;
      end
    end

    assign count_out[gi*CNT_W +: CNT_W] = count_r;
  end

endmodule

// File: tb/tb_nmlo_pulse_seq.sv
// Directed bench for nmlo_pulse_seq: an 8-bit-count instance and a 4-bit-count
// instance share all inputs; expected values are hand-computed constants.
module tb_nmlo_pulse_seq;

  logic        clk;
  logic        rst;
  logic        trigger;
  logic [7:0]  num_pulses;
  logic [7:0]  t_share;
  logic [7:0]  t_integ;
  logic [7:0]  t_latch;
  logic [15:0] comp_out;
  logic        idle, share, integ, latch, count_valid;
  logic [127:0] cnt8;
  logic        idle4, share4, integ4, latch4, count_valid4;
  logic [63:0] cnt4;

  int n_vec = 0;
  int n_bad = 0;

  // results of the last run_conv
  int           r_low, r_ns, r_ni, r_nl, r_nv, r_ovl;
  logic [31:0]  r_seq;
  logic [127:0] r_cap8;
  logic [63:0]  r_cap4;
  logic         r_to;

  nmlo_pulse_seq #(.NCOL(16), .CNT_W(8), .TIME_W(8)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .num_pulses(num_pulses),
    .t_share(t_share), .t_integ(t_integ), .t_latch(t_latch),
    .comp_out(comp_out), .idle(idle), .share(share), .integ(integ),
    .latch(latch), .count_out(cnt8), .count_valid(count_valid)
  );

  nmlo_pulse_seq #(.NCOL(16), .CNT_W(4), .TIME_W(8)) dut4 (
    .clk(clk), .rst(rst), .trigger(trigger), .num_pulses(num_pulses),
    .t_share(t_share), .t_integ(t_integ), .t_latch(t_latch),
    .comp_out(comp_out), .idle(idle4), .share(share4), .integ(integ4),
    .latch(latch4), .count_out(cnt4), .count_valid(count_valid4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] exp8(input logic [15:0] mask, input logic [7:0] v);
    logic [127:0] e;
    e = 128'd0;
    for (int i = 0; i < 16; i++) e[i*8 +: 8] = mask[i] ? v : 8'd0;
    return e;
  endfunction

  function automatic logic [127:0] exp4(input logic [15:0] mask, input logic [3:0] v);
    logic [127:0] e;
    e = 128'd0;
    for (int i = 0; i < 16; i++) e[i*4 +: 4] = mask[i] ? v : 4'd0;
    return e;
  endfunction

  // Caller raises trigger with config set; this drops trigger after the
  // accepting edge and observes until idle returns high.
  task automatic run_conv(input int budget);
    logic seen;
    seen = 1'b0;
    r_low = 0; r_ns = 0; r_ni = 0; r_nl = 0; r_nv = 0; r_ovl = 0;
    r_seq = 32'd0; r_cap8 = 128'd0; r_cap4 = 64'd0; r_to = 1'b1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      trigger = 1'b0;
      if (share) begin r_ns++; r_seq = {r_seq[29:0], 2'b01}; end
      if (integ) begin r_ni++; r_seq = {r_seq[29:0], 2'b10}; end
      if (latch) begin r_nl++; r_seq = {r_seq[29:0], 2'b11}; end
      if ((32'(share) + 32'(integ) + 32'(latch)) > 32'd1) r_ovl++;
      if (count_valid) begin r_nv++; r_cap8 = cnt8; r_cap4 = cnt4; end
      if (!idle) begin
        r_low++;
        seen = 1'b1;
      end else if (seen) begin
        r_to = 1'b0;
        break;
      end
    end
  endtask

  initial begin
    int c, lowc, conv, extra;
    rst = 1'b1; trigger = 1'b0; num_pulses = 8'd0;
    t_share = 8'd0; t_integ = 8'd0; t_latch = 8'd0; comp_out = 16'd0;

    // ---- reset state ----
    repeat (2) @(negedge clk);
    chk("rst_idle", 128'(idle), 128'd0);
    chk("rst_pulses", 128'({share, integ, latch, count_valid}), 128'd0);
    chk("rst_counts", cnt8, 128'd0);
    rst = 1'b0;
    chk("rst_rel_idle0", 128'(idle), 128'd0);
    @(negedge clk);
    chk("rst_rel_idle1", 128'(idle), 128'd1);

    // ---- basic conversion: 3 pulses, t=2, comp 00FF ----
    num_pulses = 8'd3; t_share = 8'd2; t_integ = 8'd2; t_latch = 8'd2;
    comp_out = 16'h00FF; trigger = 1'b1;
    run_conv(100);
    chk("basic_timeout", 128'(r_to), 128'd0);
    chk("basic_low", 128'(r_low), 128'd20);
    chk("basic_share", 128'(r_ns), 128'd6);
    chk("basic_integ", 128'(r_ni), 128'd6);
    chk("basic_latch", 128'(r_nl), 128'd6);
    chk("basic_overlap", 128'(r_ovl), 128'd0);
    chk("basic_valid", 128'(r_nv), 128'd1);
    chk("basic_counts", r_cap8, exp8(16'h00FF, 8'd3));
    repeat (3) @(negedge clk);
    chk("basic_hold", cnt8, exp8(16'h00FF, 8'd3));

    // ---- zero pulses ----
    num_pulses = 8'd0; trigger = 1'b1;
    run_conv(50);
    chk("zero_low", 128'(r_low), 128'd2);
    chk("zero_pulses", 128'(r_ns + r_ni + r_nl), 128'd0);
    chk("zero_valid", 128'(r_nv), 128'd1);
    chk("zero_counts", r_cap8, 128'd0);

    // ---- zero-length phases, 2 pulses ----
    num_pulses = 8'd2; t_share = 8'd0; t_integ = 8'd0; t_latch = 8'd0;
    comp_out = 16'hA5A5; trigger = 1'b1;
    run_conv(50);
    chk("t0_low", 128'(r_low), 128'd8);
    chk("t0_order", 128'(r_seq), 128'h6DB);
    chk("t0_overlap", 128'(r_ovl), 128'd0);
    chk("t0_counts8", r_cap8, exp8(16'hA5A5, 8'd2));
    chk("t0_counts4", 128'(r_cap4), exp4(16'hA5A5, 4'd2));

    // ---- saturation ----
    num_pulses = 8'd255; comp_out = 16'hFFFF; trigger = 1'b1;
    run_conv(1000);
    chk("sat1_low", 128'(r_low), 128'd767);
    chk("sat1_counts8", r_cap8, exp8(16'hFFFF, 8'd255));
    chk("sat1_counts4", 128'(r_cap4), exp4(16'hFFFF, 4'd15));
    trigger = 1'b1;
    run_conv(1000);
    chk("sat2_counts8", r_cap8, exp8(16'hFFFF, 8'd255));
    num_pulses = 8'd20; trigger = 1'b1;
    run_conv(200);
    chk("sat20_counts8", r_cap8, exp8(16'hFFFF, 8'd20));
    chk("sat20_counts4", 128'(r_cap4), exp4(16'hFFFF, 4'd15));

    // ---- reset in the middle of the second latch phase ----
    num_pulses = 8'd3; t_share = 8'd2; t_integ = 8'd2; t_latch = 8'd2;
    comp_out = 16'hFFFF; trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    c = 0;
    while (latch !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    while (latch !== 1'b0 && c < 50) begin @(negedge clk); c++; end
    while (latch !== 1'b1 && c < 50) begin @(negedge clk); c++; end
    chk("mid_reach_latch", 128'(latch), 128'd1);
    chk("mid_counts", cnt8, exp8(16'hFFFF, 8'd1));
    rst = 1'b1;
    #1;
    chk("mid_rst_latch", 128'(latch), 128'd0);
    chk("mid_rst_counts", cnt8, 128'd0);
    chk("mid_rst_idle", 128'(idle), 128'd0);
    chk("mid_rst_other", 128'({share, integ, count_valid}), 128'd0);
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rel_idle0", 128'(idle), 128'd0);
    @(negedge clk);
    chk("mid_rel_idle1", 128'(idle), 128'd1);

    // ---- handshake: 3 conversions, trigger held until idle low ----
    conv = 0;
    for (int k = 0; k < 3; k++) begin
      num_pulses = 8'd1; t_share = 8'd1; t_integ = 8'd1; t_latch = 8'd1;
      comp_out = 16'h000F; trigger = 1'b1;
      c = 0;
      while (idle !== 1'b0 && c < 20) begin @(negedge clk); c++; end
      chk("hs_accept", 128'(idle), 128'd0);
      trigger = 1'b0;
      num_pulses = 8'd9; t_share = 8'd7; t_integ = 8'd7; t_latch = 8'd7;
      lowc = 1;
      c = 0;
      while (idle !== 1'b1 && c < 40) begin
        @(negedge clk);
        c++;
        if (count_valid) begin conv++; r_cap8 = cnt8; end
        if (!idle) lowc++;
      end
      chk("hs_low", 128'(lowc), 128'd5);
      chk("hs_counts", r_cap8, exp8(16'h000F, 8'd1));
    end
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (!idle) extra++;
    end
    chk("hs_no_restart", 128'(extra), 128'd0);
    chk("hs_conversions", 128'(conv), 128'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
